// File: rtl/pin_wiggler_pkg.sv
// Shared types for the pin-wiggler counter and its loopback checker.
// Holds the checker FSM states and the default bus widths.
package pin_wiggler_pkg;

  localparam int DATA_W = 16;
  localparam int ERR_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    LOCKED
  } state_t;

endpackage

// File: rtl/bus_sync.sv
// Two-flop synchroniser for a WIDTH-bit bus, synchronous reset to 0.
// Ports: clk, reset, d (async bus in), q (synchronised bus out).
module bus_sync
  import pin_wiggler_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/loopback_board.sv
// Board wrapper: Pmod JC carries bits 7:0, JD bits 15:8.
// Ports: clk, reset, clear, jc0..jc7, jd0..jd7 in; led, led1 and debug out.
module loopback_board
  import pin_wiggler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              jc0, jc1, jc2, jc3,
  input  logic              jc4, jc5, jc6, jc7,
  input  logic              jd0, jd1, jd2, jd3,
  input  logic              jd4, jd5, jd6, jd7,
  output logic              led,
  output logic              led1,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [DATA_W-1:0] last_word
);

  logic [15:0] rx;

  assign rx = {jd7, jd6, jd5, jd4, jd3, jd2, jd1, jd0,
               jc7, jc6, jc5, jc4, jc3, jc2, jc1, jc0};

  loopback_checker u_chk (
    .clk       (clk),
    .reset     (reset),
    .rx_pins   (rx),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .last_word (last_word),
    .led_ok    (led),
    .led_err   (led1)
  );

endmodule

// File: rtl/loopback_checker.sv
// Checks that the looped-back counter advances by exactly 1 per clock.
// Ports: clk, reset, rx_pins, clear in; locked, err_pulse, err_count,
// last_word, led_ok, led_err out (all registered).
module loopback_checker
  import pin_wiggler_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_WIDTH  = ERR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     rx_pins,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]     last_word,
  output logic                 led_ok,
  output logic                 led_err
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_COUNT - 1);

  state_t           state;
  logic [1:0]       idle_cnt;
  logic [MW-1:0]    match_cnt;
  logic [LW-1:0]    miss_cnt;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] expected;
  logic             match;
  logic             miss_err;

  bus_sync #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_pins),
    .q     (sync2)
  );

  assign expected  = prev + WIDTH'(1);
  assign match     = (sync2 == expected);
  assign miss_err  = (state == LOCKED) && !match;
  assign last_word = sync2;
  assign led_ok    = locked;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_count <= '0;
      led_err   <= 1'b0;
    end else begin
      err_pulse <= miss_err;
      // clear beats a simultaneous error
      if (clear) begin
        err_count <= '0;
        led_err   <= 1'b0;
      end else if (miss_err) begin
        led_err <= 1'b1;
        if (err_count != '1)
          err_count <= err_count + ERR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      locked    <= 1'b0;
      idle_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      prev      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // two cycles to fill the synchroniser, one to prime prev
          if (idle_cnt == 2'd2) begin
            idle_cnt <= '0;
            prev     <= sync2;
            state    <= SEARCH;
          end else begin
            idle_cnt <= idle_cnt + 2'd1;
          end
        end
        SEARCH: begin
          prev <= sync2;
          if (!match) begin
            match_cnt <= '0;
          end else if (match_cnt == LOCK_LAST) begin
            match_cnt <= '0;
            state     <= LOCKED;
            locked    <= 1'b1;
          end else begin
            match_cnt <= match_cnt + MW'(1);
          end
        end
        LOCKED: begin
          if (match) begin
            prev     <= sync2;
            miss_cnt <= '0;
          end else begin
            // flywheel: keep counting on our own so one bad word
            // costs exactly one error
            prev <= expected;
            if (miss_cnt == LOSS_LAST) begin
              miss_cnt <= '0;
              state    <= SEARCH;
              locked   <= 1'b0;
            end else begin
              miss_cnt <= miss_cnt + LW'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loopback_checker.sv
// Scoreboard bench for loopback_checker (16-bit and 2-bit error counters).
// Stimulus pushes predicted outputs; a negedge monitor pops and compares.
module tb_loopback_checker;

  bit          clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [15:0] rx_pins;

  logic        locked, err_pulse, led_ok, led_err;
  logic [15:0] err_count, last_word;
  logic        locked2, err_pulse2, led_ok2, led_err2;
  logic [1:0]  err_count2;
  logic [15:0] last_word2;

  always #5 clk = ~clk;

  loopback_checker dut (
    .clk       (clk),
    .reset     (reset),
    .rx_pins   (rx_pins),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .last_word (last_word),
    .led_ok    (led_ok),
    .led_err   (led_err)
  );

  loopback_checker #(.ERR_WIDTH(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .rx_pins   (rx_pins),
    .clear     (clear),
    .locked    (locked2),
    .err_pulse (err_pulse2),
    .err_count (err_count2),
    .last_word (last_word2),
    .led_ok    (led_ok2),
    .led_err   (led_err2)
  );

  typedef struct {
    bit        lk;
    bit        pulse;
    int        errs;
    int        errs2;
    bit        led_e;
    bit [15:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: words reach the comparator two edges after the pins.
  // Lock needs LOCK_COUNT good steps in a row, loss LOSS_COUNT bad ones.
  bit [15:0] pipe[$];
  int        warmup;
  bit        m_lk;
  bit [15:0] m_ref;
  int        good_run, bad_run;
  int        m_errs, m_errs2;
  bit        m_led;

  task automatic model_edge(input bit [15:0] p, input bit r, input bit c);
    exp_t      e;
    bit [15:0] w;
    bit        pulse;
    pulse = 1'b0;
    if (r) begin
      pipe     = '{16'h0, 16'h0};
      warmup   = 3;
      m_lk     = 1'b0;
      m_ref    = 16'h0;
      good_run = 0;
      bad_run  = 0;
      m_errs   = 0;
      m_errs2  = 0;
      m_led    = 1'b0;
    end else begin
      w = pipe[1];
      if (warmup > 0) begin
        warmup--;
        if (warmup == 0) m_ref = w;
      end else if (!m_lk) begin
        good_run = (w == m_ref + 16'd1) ? good_run + 1 : 0;
        m_ref = w;
        if (good_run == 8) begin
          m_lk = 1'b1;
          good_run = 0;
        end
      end else if (w == m_ref + 16'd1) begin
        m_ref = w;
        bad_run = 0;
      end else begin
        m_ref = m_ref + 16'd1;
        pulse = 1'b1;
        bad_run++;
        if (bad_run == 4) begin
          m_lk = 1'b0;
          bad_run = 0;
        end
      end
      if (c) begin
        m_errs = 0;
        m_errs2 = 0;
        m_led = 1'b0;
      end else if (pulse) begin
        m_led = 1'b1;
        if (m_errs < 65535) m_errs++;
        if (m_errs2 < 3) m_errs2++;
      end
      pipe = '{p, pipe[0]};
    end
    e.lk    = m_lk;
    e.pulse = pulse;
    e.errs  = m_errs;
    e.errs2 = m_errs2;
    e.led_e = m_led;
    e.word  = pipe[1];
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("locked", int'(locked), int'(e.lk));
      chk("led_ok", int'(led_ok), int'(e.lk));
      chk("err_pulse", int'(err_pulse), int'(e.pulse));
      chk("err_count", int'(err_count), e.errs);
      chk("led_err", int'(led_err), int'(e.led_e));
      chk("last_word", int'(last_word), int'(e.word));
      chk("locked_w2", int'(locked2), int'(e.lk));
      chk("err_count_w2", int'(err_count2), e.errs2);
    end
  end

  bit [15:0] cur;

  task automatic tick(input bit [15:0] p, input bit r = 1'b0,
                      input bit c = 1'b0);
    rx_pins = p;
    reset   = r;
    clear   = c;
    model_edge(p, r, c);
    @(posedge clk);
    #1;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      tick(cur);
      cur++;
    end
  endtask

  initial begin
    pipe = '{16'h0, 16'h0};
    tick(16'hABCD, 1'b1);
    tick(16'hABCD, 1'b1);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_last_word", int'(last_word), 0);
    chk("rst_led_err", int'(led_err), 0);

    cur = 16'h0000;
    for (int i = 1; i <= 11; i++) begin
      tick(cur);
      cur++;
      if (i == 10) chk("lock_not_early", int'(locked), 0);
      if (i == 11) chk("lock_at_11", int'(locked), 1);
    end
    clean(5);
    chk("clean_err_count", int'(err_count), 0);

    tick(16'h0, 1'b1);
    cur = 16'hFFE8;
    clean(27);
    chk("wrap_locked", int'(locked), 1);
    chk("wrap_err_count", int'(err_count), 0);

    tick(16'h0, 1'b1);
    cur = 16'h00F0;
    clean(17);
    tick(16'h0141);
    cur++;
    clean(6);
    chk("glitch_err_count", int'(err_count), 1);
    chk("glitch_led_err", int'(led_err), 1);
    chk("glitch_locked", int'(locked), 1);

    repeat (4) tick(16'h1234);
    cur = 16'h1235;
    clean(2);
    chk("loss_err_count", int'(err_count), 5);
    chk("loss_unlocked", int'(locked), 0);
    clean(12);
    chk("relock", int'(locked), 1);

    tick(16'h0, 1'b1);
    cur = 16'h4000;
    clean(12);
    for (int g = 0; g < 5; g++) begin
      tick(cur ^ 16'h0800);
      cur++;
      clean(4);
    end
    chk("sat_err_w2", int'(err_count2), 3);
    chk("sat_err_w16", int'(err_count), 5);

    tick(cur ^ 16'h0040);
    cur++;
    tick(cur);
    cur++;
    tick(cur, 1'b0, 1'b1);
    cur++;
    chk("clr_pulse", int'(err_pulse), 1);
    chk("clr_err_count", int'(err_count), 0);
    chk("clr_led_err", int'(led_err), 0);
    clean(3);

    tick(cur, 1'b1);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_err_count", int'(err_count), 0);
    cur = 16'h0000;
    clean(10);
    chk("midrst_not_early", int'(locked), 0);
    clean(1);
    chk("midrst_relock", int'(locked), 1);

    for (int i = 0; i < 3000; i++) begin
      bit r, c;
      bit [15:0] p;
      r = ($urandom_range(0, 599) == 0);
      c = ($urandom_range(0, 49) == 0);
      p = cur;
      if ($urandom_range(0, 15) == 0)
        p = cur ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0)
        cur = 16'($urandom);
      tick(p, r, c);
      cur++;
    end

    clean(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
